// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: time-shares one external full-adder cell,
// one operand bit per clock, LSB first, behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = op_a;
                    b_sh_d   = op_b;
                    c_d      = cin;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                fa_a   = a_sh_q[0];
                fa_b   = b_sh_q[0];
                fa_cin = c_q;
                // Sum bits enter at the MSB so bit i lands in place after WIDTH shifts.
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                c_d      = fa_carry;
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign cout   = cout_q;

endmodule
